player_move: RTL and testbench
==============================

PLAYER_MOVE -- requirements
Module: player_move

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 state  in  4  game state code from the game state FSM (TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8).
REQ-004 move_req  in  1  one-cycle move request pulse from the keyboard path.
REQ-005 move_dir  in  2  direction qualified by move_req: 0 up, 1 left, 2 down, 3 right.
REQ-006 tick  in  1  pixel-step enable; one pixel of motion per asserted cycle.
REQ-007 player_x, player_y  out  9 each  player top-left pixel coordinate.
REQ-008 key_x, key_y  out  9 each  key top-left pixel coordinate; 9'h1FF = key hidden.
REQ-009 has_key  out  1  key collected in the current stage attempt.
REQ-010 busy  out  1  move in progress; new requests ignored.
REQ-011 steps  out  8  completed moves in the current stage attempt.
REQ-012 pass, fail  out  1 each  one-cycle pulses to the game state FSM.
REQ-013 Parameters: TILE=16 (px), COLS=20, ROWS=15, STEP_LIMIT=40 (stage 3 only).

Function
REQ-014 Control FSM states: IDLE, CHECK, EVAL, MOVE, ARRIVE, LOCKED.
REQ-015 Stage entry = state changes into STAGE1/2/3 (registered previous state differs); on the next edge load stage start and key tile positions, clear has_key and steps, and go to IDLE; entry overrides any other activity, including a move in progress.
REQ-016 When state is not STAGE1/2/3, the FSM stays in IDLE/LOCKED, ignores move_req, and holds all positions.
REQ-017 IDLE: move_req=1 -> compute target tile (current tile +/-1); go to CHECK; busy=1 from the next cycle until return to IDLE.
REQ-018 CHECK: target outside 0..COLS-1 / 0..ROWS-1 -> IDLE (rejected, steps unchanged); otherwise present the target to the map ROM.
REQ-019 EVAL: ROM tile WALL -> IDLE (rejected); FLOOR or EXIT -> MOVE.
REQ-020 MOVE: on each tick the moving coordinate changes by +/-1 px; after 16 ticks go to ARRIVE; cycles without tick hold position.
REQ-021 ARRIVE (one cycle): steps+1 (saturate at 255); if arrival tile is the key tile and has_key=0, set has_key and hide the key (key_x=key_y=9'h1FF).
REQ-022 In ARRIVE, on an EXIT tile with has_key=1 (including a key picked up on that same arrival): pulse pass and go to LOCKED; an EXIT tile without the key has no effect.
REQ-023 In STAGE3 only, if steps reaches STEP_LIMIT in ARRIVE without pass: pulse fail and go to LOCKED; pass wins when both conditions hold.
REQ-024 Otherwise ARRIVE -> IDLE.
REQ-025 LOCKED ignores move_req and leaves only on stage entry (covers a FAIL-to-STAGE3 retry).
REQ-026 move_req while busy or LOCKED is dropped; there is no queue.
REQ-027 Positions are always whole-tile multiples of TILE except during MOVE.

Reset
REQ-028 While rst=1, all outputs take their reset values asynchronously: player_x=player_y=0, key_x=key_y=9'h1FF, has_key=0, steps=0, busy=0, pass=fail=0, FSM=IDLE, previous-state register=TITLE.
REQ-029 rst asserted mid-move aborts the move with no pass/fail pulse.

Structure
REQ-030 The shared package holds the state codes, direction codes, tile-type codes (FLOOR=0, WALL=1, EXIT=2), TILE/COLS/ROWS, and per-stage start and key tile constants.
REQ-031 Stage 1 layout: start tile (1,1), key tile (3,1), exit tile (18,13), wall tile (1,2).
REQ-032 Sub-module stage_map: synchronous ROM with inputs stage[1:0], col[4:0], row[3:0] and a 2-bit tile output registered with 1-cycle latency; all grid border tiles are WALL except the exit.

Verification
REQ-033 Reset, then state 0->2 -> player (16,16), key (48,16), has_key=0, steps=0.
REQ-034 STAGE1 at (16,16), move down (tile (1,2) is WALL) -> busy for 2 cycles, position unchanged, steps=0.
REQ-035 STAGE1, two right moves with tick held high -> each move takes 16 ticks; after the second move player (48,16), has_key=1, key=(1FF,1FF), steps=2.
REQ-036 STAGE1 with the key, a move arrives at tile (18,13) -> pass high exactly one cycle; later move_req ignored; same arrival without the key -> no pass.
REQ-037 STAGE3, 40 legal moves without pass -> fail pulse in the 40th ARRIVE cycle; state 8->6 reloads the stage 3 start position and steps=0.
REQ-038 move_req during MOVE, and rst mid-move -> request dropped; reset values seen immediately and no pulses.

Source files
------------

// File: rtl/player_move_pkg.sv
// player_move_pkg: game-state, direction and tile codes, grid geometry and
// per-stage start/key/exit tiles shared by player_move and stage_map.
package player_move_pkg;
   localparam int         TILE       = 16;
   localparam logic [5:0] COLS       = 6'd20;
   localparam logic [5:0] ROWS       = 6'd15;
   localparam logic [4:0] LAST_COL   = 5'(COLS - 6'd1);
   localparam logic [3:0] LAST_ROW   = 4'(ROWS - 6'd1);
   localparam logic [7:0] STEP_LIMIT = 8'd40;

   typedef enum logic [3:0] {
      TITLE = 4'd0, STAFF = 4'd1, STAGE1 = 4'd2, SUCCESS1 = 4'd3, STAGE2 = 4'd4,
      SUCCESS2 = 4'd5, STAGE3 = 4'd6, SUCCESS3 = 4'd7, FAIL = 4'd8
   } game_state_e;

   typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_LEFT = 2'd1, DIR_DOWN = 2'd2, DIR_RIGHT = 2'd3} dir_e;
   typedef enum logic [1:0] {FLOOR = 2'd0, WALL = 2'd1, EXIT = 2'd2} tile_e;
   typedef enum logic [2:0] {IDLE, CHECK, EVAL, MOVE, ARRIVE, LOCKED} ctrl_e;

   typedef struct packed {
      logic [4:0] col;
      logic [3:0] row;
   } tile_t;

   // Stage index is 1..3; anything else falls back to the stage 1 layout.
   function automatic tile_t start_tile(input logic [1:0] stage);
      return (stage == 2'd2) ? {5'd1, 4'd13} : (stage == 2'd3) ? {5'd2, 4'd2} : {5'd1, 4'd1};
   endfunction

   function automatic tile_t key_tile(input logic [1:0] stage);
      return (stage == 2'd2) ? {5'd9, 4'd2} : (stage == 2'd3) ? {5'd17, 4'd12} : {5'd3, 4'd1};
   endfunction

   function automatic tile_t exit_tile(input logic [1:0] stage);
      return (stage == 2'd2) ? {5'd18, 4'd1} : (stage == 2'd3) ? {5'd10, 4'd7} : {5'd18, 4'd13};
   endfunction
endpackage

// File: rtl/player_move_stage_map.sv
// stage_map: per-stage tile ROM; border and interior walls, one exit tile,
// output registered with one cycle of latency.
module stage_map
   import player_move_pkg::*;
(
   input  logic       clk,
   input  logic [1:0] stage,
   input  logic [4:0] col,
   input  logic [3:0] row,
   output logic [1:0] tile
);
   tile_t ex;
   logic  border, inner;

   assign ex     = exit_tile(stage);
   assign border = (col == 5'd0) || (col == LAST_COL) || (row == 4'd0) || (row == LAST_ROW);
   assign inner  = (stage == 2'd2) ? (col == 5'd10) && (row >= 4'd3) && (row <= 4'd13) :
                   (stage == 2'd3) ? (row == 4'd5) && (col >= 5'd1) && (col <= 5'd14) :
                                     (col == 5'd1) && (row == 4'd2);

   always_ff @(posedge clk)
      tile <= ({col, row} == ex) ? EXIT : (border || inner) ? WALL : FLOOR;
endmodule

// File: rtl/player_move.sv
// player_move: tile-stepped player control for the three stages -- bounds and
// wall checks, pixel-stepped motion, key pickup, step count and pass/fail pulses.
module player_move
   import player_move_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] state,
   input  logic       move_req,
   input  logic [1:0] move_dir,
   input  logic       tick,
   output logic [8:0] player_x,
   output logic [8:0] player_y,
   output logic [8:0] key_x,
   output logic [8:0] key_y,
   output logic       has_key,
   output logic       busy,
   output logic [7:0] steps,
   output logic       pass,
   output logic       fail
);
   ctrl_e      st_q, st_d;
   logic [3:0] prev_q, cnt_q, cnt_d;
   logic [8:0] px_q, px_d, py_q, py_d, kx_q, kx_d, ky_q, ky_d;
   logic [5:0] tx_q, tx_d, ty_q, ty_d;
   logic [1:0] dir_q, dir_d, stage, tile;
   logic [7:0] steps_q, steps_d, steps_inc;
   logic       hk_q, hk_d, in_stage, entry, key_hit;
   tile_t      st_tile, ky_tile;

   assign in_stage  = (state == STAGE1) || (state == STAGE2) || (state == STAGE3);
   assign entry     = in_stage && (state != prev_q);
   assign stage     = state[2:1];
   assign st_tile   = start_tile(stage);
   assign ky_tile   = key_tile(stage);
   assign steps_inc = steps_q + {7'd0, steps_q != 8'hFF};
   assign key_hit   = !hk_q && (px_q == kx_q) && (py_q == ky_q);

   stage_map u_map (
      .clk  (clk),
      .stage(stage),
      .col  (tx_q[4:0]),
      .row  (ty_q[3:0]),
      .tile (tile)
   );

   always_comb begin
      st_d = st_q;
      px_d = px_q;
      py_d = py_q;
      kx_d = kx_q;
      ky_d = ky_q;
      tx_d = tx_q;
      ty_d = ty_q;
      dir_d = dir_q;
      cnt_d = cnt_q;
      steps_d = steps_q;
      hk_d = hk_q;
      pass = 1'b0;
      fail = 1'b0;
      if (entry) begin
         st_d = IDLE;
         px_d = {st_tile.col, 4'd0};
         py_d = {1'b0, st_tile.row, 4'd0};
         kx_d = {ky_tile.col, 4'd0};
         ky_d = {1'b0, ky_tile.row, 4'd0};
         steps_d = '0;
         hk_d = 1'b0;
      end else if (!in_stage) begin
         st_d = (st_q == LOCKED) ? LOCKED : IDLE;
      end else begin
         unique case (st_q)
            IDLE: if (move_req) begin
               // Targets wrap to all-ones below zero, so one unsigned compare covers both edges.
               tx_d = {1'b0, px_q[8:4]} + ((move_dir == DIR_RIGHT) ? 6'd1 : (move_dir == DIR_LEFT) ? 6'h3F : 6'd0);
               ty_d = {1'b0, py_q[8:4]} + ((move_dir == DIR_DOWN) ? 6'd1 : (move_dir == DIR_UP) ? 6'h3F : 6'd0);
               dir_d = move_dir;
               st_d = CHECK;
            end
            CHECK: st_d = ((tx_q < COLS) && (ty_q < ROWS)) ? EVAL : IDLE;
            EVAL: begin
               cnt_d = '0;
               st_d = (tile == WALL) ? IDLE : MOVE;
            end
            MOVE: if (tick) begin
               px_d = (dir_q == DIR_RIGHT) ? px_q + 9'd1 : (dir_q == DIR_LEFT) ? px_q - 9'd1 : px_q;
               py_d = (dir_q == DIR_DOWN) ? py_q + 9'd1 : (dir_q == DIR_UP) ? py_q - 9'd1 : py_q;
               cnt_d = cnt_q + 4'd1;
               st_d = (cnt_q == 4'd15) ? ARRIVE : MOVE;
            end
            ARRIVE: begin
               steps_d = steps_inc;
               hk_d = hk_q | key_hit;
               kx_d = key_hit ? '1 : kx_q;
               ky_d = key_hit ? '1 : ky_q;
               pass = (tile == EXIT) && hk_d;
               fail = !pass && (state == STAGE3) && (steps_inc == STEP_LIMIT);
               st_d = (pass || fail) ? LOCKED : IDLE;
            end
            default: st_d = st_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st_q <= IDLE;
         prev_q <= TITLE;
         px_q <= '0;
         py_q <= '0;
         kx_q <= '1;
         ky_q <= '1;
         tx_q <= '0;
         ty_q <= '0;
         dir_q <= '0;
         cnt_q <= '0;
         steps_q <= '0;
         hk_q <= 1'b0;
      end else begin
         st_q <= st_d;
         prev_q <= state;
         px_q <= px_d;
         py_q <= py_d;
         kx_q <= kx_d;
         ky_q <= ky_d;
         tx_q <= tx_d;
         ty_q <= ty_d;
         dir_q <= dir_d;
         cnt_q <= cnt_d;
         steps_q <= steps_d;
         hk_q <= hk_d;
      end

   assign player_x = px_q;
   assign player_y = py_q;
   assign key_x    = kx_q;
   assign key_y    = ky_q;
   assign has_key  = hk_q;
   assign steps    = steps_q;
   assign busy     = (st_q != IDLE) && (st_q != LOCKED);
endmodule

// File: tb/tb_player_move.sv
// tb_player_move: constant vector table, hand-written corner sequences and
// randomized moves checked against a tile-level reference model.
module tb_player_move;
   logic       clk = 1'b0, rst = 1'b1;
   logic [3:0] state = 4'd0;
   logic       move_req = 1'b0, tick = 1'b0;
   logic [1:0] move_dir = 2'd0;
   logic [8:0] player_x, player_y, key_x, key_y;
   logic       has_key, busy, pass, fail;
   logic [7:0] steps;
   int n_cmp = 0, n_mis = 0;
   int bc, np, nf;
   int m_stage, mc, mr, mk, ms, m_locked;
   int sc[4] = '{0, 1, 1, 2};
   int sr[4] = '{0, 1, 13, 2};
   int kc[4] = '{0, 3, 9, 17};
   int kr[4] = '{0, 1, 2, 12};

   typedef struct {int dir; int ent; int x; int y; int stp; int key; int ps; int bsy;} vec_t;
   vec_t vq[$];

   always #5 clk = ~clk;

   player_move dut (
      .clk(clk), .rst(rst), .state(state), .move_req(move_req), .move_dir(move_dir), .tick(tick),
      .player_x(player_x), .player_y(player_y), .key_x(key_x), .key_y(key_y),
      .has_key(has_key), .busy(busy), .steps(steps), .pass(pass), .fail(fail)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int tile_of(input int stg, input int c, input int r);
      int ec = (stg == 3) ? 10 : 18;
      int er = (stg == 2) ? 1 : (stg == 3) ? 7 : 13;
      if (c == ec && r == er) return 2;
      if (c <= 0 || r <= 0 || c >= 19 || r >= 14) return 1;
      if (stg == 2 && c == 10 && r >= 3 && r <= 13) return 1;
      if (stg == 3 && r == 5 && c >= 1 && c <= 14) return 1;
      if (stg != 2 && stg != 3 && c == 1 && r == 2) return 1;
      return 0;
   endfunction

   task automatic model_move(input int d, output int ep, output int ef);
      int c = mc + ((d == 3) ? 1 : 0) - ((d == 1) ? 1 : 0);
      int r = mr + ((d == 2) ? 1 : 0) - ((d == 0) ? 1 : 0);
      ep = 0;
      ef = 0;
      if (!m_locked && c >= 0 && r >= 0 && c < 20 && r < 15 && tile_of(m_stage, c, r) != 1) begin
         mc = c;
         mr = r;
         if (ms < 255) ms++;
         if (!mk && c == kc[m_stage] && r == kr[m_stage]) mk = 1;
         if (tile_of(m_stage, c, r) == 2 && mk) ep = 1;
         else if (m_stage == 3 && ms == 40) ef = 1;
         m_locked = ep | ef;
      end
   endtask

   task automatic enter_stage(input int stg);
      @(negedge clk) state = 4'd0;
      @(negedge clk) state = 4'(2 * stg);
      @(negedge clk);
      m_stage = stg;
      mc = sc[stg];
      mr = sr[stg];
      mk = 0;
      ms = 0;
      m_locked = 0;
   endtask

   // Issue one request, then sample busy/pass/fail on every falling edge until busy drops.
   task automatic do_move(input int d, input bit hold);
      @(negedge clk);
      move_req = 1'b1;
      move_dir = 2'(d);
      tick = 1'b1;
      @(negedge clk) move_req = 1'b0;
      bc = 0;
      np = 0;
      nf = 0;
      while (busy && bc < 400) begin
         np += int'(pass);
         nf += int'(fail);
         bc++;
         tick = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
         @(negedge clk);
      end
      tick = 1'b0;
      if (bc >= 400) chk("move_timeout", bc, 0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_x"}, player_x, 0);
      chk({tag, "_y"}, player_y, 0);
      chk({tag, "_kx"}, key_x, 511);
      chk({tag, "_ky"}, key_y, 511);
      chk({tag, "_key"}, has_key, 0);
      chk({tag, "_steps"}, steps, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_fail"}, fail, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d, ep, ef, stg, wl, cyc;
      vq.push_back('{2, 1, 16, 16, 0, 0, 0, 2});
      vq.push_back('{0, 0, 16, 16, 0, 0, 0, 2});
      vq.push_back('{1, 0, 16, 16, 0, 0, 0, 2});
      vq.push_back('{3, 0, 32, 16, 1, 0, 0, 19});
      vq.push_back('{3, 0, 48, 16, 2, 1, 0, 19});
      for (int i = 1; i <= 15; i++) vq.push_back('{3, 0, 48 + 16 * i, 16, 2 + i, 1, 0, 19});
      for (int i = 1; i <= 12; i++) vq.push_back('{2, 0, 288, 16 + 16 * i, 17 + i, 1, (i == 12) ? 1 : 0, 19});
      vq.push_back('{3, 0, 288, 208, 29, 1, 0, 0});
      vq.push_back('{3, 1, 32, 16, 1, 0, 0, 19});
      for (int i = 1; i <= 12; i++) vq.push_back('{2, 0, 32, 16 + 16 * i, 1 + i, 0, 0, 19});
      for (int i = 1; i <= 16; i++) vq.push_back('{3, 0, 32 + 16 * i, 208, 13 + i, 0, 0, 19});
      vq.push_back('{1, 0, 272, 208, 30, 0, 0, 19});

      repeat (2) @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;
      @(negedge clk) state = 4'd2;
      @(negedge clk);
      chk("entry_x", player_x, 16);
      chk("entry_y", player_y, 16);
      chk("entry_kx", key_x, 48);
      chk("entry_ky", key_y, 16);
      chk("entry_key", has_key, 0);
      chk("entry_steps", steps, 0);

      foreach (vq[i]) begin
         if (vq[i].ent != 0) enter_stage(1);
         do_move(vq[i].dir, 1'b1);
         chk($sformatf("vec%0d_x", i), player_x, vq[i].x);
         chk($sformatf("vec%0d_y", i), player_y, vq[i].y);
         chk($sformatf("vec%0d_steps", i), steps, vq[i].stp);
         chk($sformatf("vec%0d_key", i), has_key, vq[i].key);
         chk($sformatf("vec%0d_kx", i), key_x, (vq[i].key != 0) ? 511 : 48);
         chk($sformatf("vec%0d_ky", i), key_y, (vq[i].key != 0) ? 511 : 16);
         chk($sformatf("vec%0d_pass", i), np, vq[i].ps);
         chk($sformatf("vec%0d_busy", i), bc, vq[i].bsy);
      end

      // A second request during MOVE is dropped, not queued.
      enter_stage(1);
      @(negedge clk);
      move_req = 1'b1;
      move_dir = 2'd3;
      tick = 1'b0;
      @(negedge clk) move_req = 1'b0;
      repeat (3) @(negedge clk);
      move_req = 1'b1;
      move_dir = 2'd2;
      @(negedge clk) move_req = 1'b0;
      chk("drop_busy_mid", busy, 1);
      tick = 1'b1;
      cyc = 0;
      while (busy && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      tick = 1'b0;
      chk("drop_x", player_x, 32);
      chk("drop_y", player_y, 16);
      chk("drop_steps", steps, 1);
      @(negedge clk);
      chk("drop_no_queue", busy, 0);

      // Reset during MOVE aborts at once.
      enter_stage(1);
      @(negedge clk);
      move_req = 1'b1;
      move_dir = 2'd3;
      tick = 1'b1;
      @(negedge clk) move_req = 1'b0;
      repeat (6) @(negedge clk);
      chk("midmove_moving", (player_x > 16 && player_x < 32) ? 1 : 0, 1);
      #2 rst = 1'b1;
      #1 chk_reset("async_rst");
      np = 0;
      nf = 0;
      repeat (3) begin
         @(negedge clk);
         np += int'(pass);
         nf += int'(fail);
      end
      chk("rst_no_pass", np, 0);
      chk("rst_no_fail", nf, 0);
      tick = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_reentry_x", player_x, 16);
      chk("rst_reentry_y", player_y, 16);
      chk("rst_reentry_busy", busy, 0);

      // Stage 3 step limit, then FAIL -> STAGE3 retry.
      enter_stage(3);
      for (int i = 0; i < 40; i++) begin
         do_move((i % 2 == 0) ? 3 : 1, 1'b1);
         chk($sformatf("s3_fail_%0d", i), nf, (i == 39) ? 1 : 0);
         chk($sformatf("s3_pass_%0d", i), np, 0);
         chk($sformatf("s3_x_%0d", i), player_x, (i % 2 == 0) ? 48 : 32);
      end
      chk("s3_steps", steps, 40);
      do_move(3, 1'b1);
      chk("s3_locked_busy", bc, 0);
      chk("s3_locked_x", player_x, 32);
      @(negedge clk) state = 4'd8;
      @(negedge clk) state = 4'd6;
      @(negedge clk);
      chk("s3_retry_x", player_x, 32);
      chk("s3_retry_y", player_y, 32);
      chk("s3_retry_steps", steps, 0);
      chk("s3_retry_kx", key_x, 272);
      do_move(3, 1'b1);
      chk("s3_retry_move", bc, 19);

      for (int t = 0; t < 6; t++) begin
         stg = int'($urandom_range(1, 3));
         enter_stage(stg);
         for (int k = 0; k < 45; k++) begin
            d = int'($urandom_range(0, 3));
            wl = m_locked;
            model_move(d, ep, ef);
            do_move(d, 1'b0);
            chk($sformatf("rnd%0d_%0d_x", t, k), player_x, 16 * mc);
            chk($sformatf("rnd%0d_%0d_y", t, k), player_y, 16 * mr);
            chk($sformatf("rnd%0d_%0d_steps", t, k), steps, ms);
            chk($sformatf("rnd%0d_%0d_key", t, k), has_key, mk);
            chk($sformatf("rnd%0d_%0d_kx", t, k), key_x, (mk != 0) ? 511 : 16 * kc[stg]);
            chk($sformatf("rnd%0d_%0d_pass", t, k), np, ep);
            chk($sformatf("rnd%0d_%0d_fail", t, k), nf, ef);
            chk($sformatf("rnd%0d_%0d_locked", t, k), (bc == 0) ? 1 : 0, wl);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
